// File: rtl/ram_param_clr.sv
// Single-port synchronous RAM with a clear sweep after reset or on clr; ready is high only in IDLE.
// Read and write-through have 1-cycle latency, or 2 cycles when RAM_OUT_REG_EN is defined. There is no backpressure: every IDLE cycle is an accepted access.
module ram_param_clr #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clr,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] s1_dat_q, s1_dat_d;
  logic              s1_vld_q, s1_vld_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s1_dat_d = '0;
    s1_vld_d = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = cnt_q;
    mem_wd   = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        if (clr) begin
          cnt_d = '0;
        end else begin
          // cnt wraps back to 0 as the last word is zeroed
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else begin
          s1_vld_d = 1'b1;
          if (load) begin
            mem_we   = 1'b1;
            mem_wa   = address;
            mem_wd   = in;
            s1_dat_d = in;
          end else begin
            s1_dat_d = mem[address];
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      s1_dat_q <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_dat_q <= s1_dat_d;
      s1_vld_q <= s1_vld_d;
    end
  end

  // The array is deliberately left out of reset; the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign ready = (state_q == S_IDLE);

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] s2_dat_q;
  logic              s2_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_dat_q <= '0;
      s2_vld_q <= 1'b0;
    end else if (state_q == S_CLEAR || state_d == S_CLEAR) begin
      s2_dat_q <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      s2_dat_q <= s1_dat_q;
      s2_vld_q <= s1_vld_q;
    end
  end

  assign out       = s2_dat_q;
  assign out_valid = s2_vld_q;
`else
  assign out       = s1_dat_q;
  assign out_valid = s1_vld_q;
`endif

endmodule
